// File: rtl/alu_csr_responder_pkg.sv
// Shared widths, ALUOP encodings and FSM state type for the CSR-handshaked ALU responder.
package alu_csr_responder_pkg;

  localparam int ALU_DATA_BITS    = 32;
  localparam int ALU_OP_BITS      = 4;
  localparam int ALU_CSR_IN_BITS  = 3;
  localparam int ALU_CSR_OUT_BITS = 3;
  localparam int CNT_BITS         = 4;

  localparam logic [ALU_OP_BITS-1:0] ALUOP_ADD  = 4'd0;
  localparam logic [ALU_OP_BITS-1:0] ALUOP_SUB  = 4'd1;
  localparam logic [ALU_OP_BITS-1:0] ALUOP_AND  = 4'd2;
  localparam logic [ALU_OP_BITS-1:0] ALUOP_OR   = 4'd3;
  localparam logic [ALU_OP_BITS-1:0] ALUOP_XOR  = 4'd4;
  localparam logic [ALU_OP_BITS-1:0] ALUOP_SLL  = 4'd5;
  localparam logic [ALU_OP_BITS-1:0] ALUOP_SRL  = 4'd6;
  localparam logic [ALU_OP_BITS-1:0] ALUOP_SRA  = 4'd7;
  localparam logic [ALU_OP_BITS-1:0] ALUOP_SLT  = 4'd8;
  localparam logic [ALU_OP_BITS-1:0] ALUOP_SLTU = 4'd9;
  localparam logic [ALU_OP_BITS-1:0] ALUOP_MUL  = 4'd10;

  typedef enum logic [2:0] {
    ST_READY_OP1 = 3'd0,
    ST_READY_OP2 = 3'd1,
    ST_EXEC      = 3'd2,
    ST_WRITE     = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // Status bits advertised while sitting in a given state; at most one is ever set.
  function automatic logic [ALU_CSR_OUT_BITS-1:0] csr_out_for(input state_e s);
    case (s)
      ST_READY_OP1: return 3'b001;
      ST_READY_OP2: return 3'b010;
      ST_DONE:      return 3'b100;
      default:      return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/alu_csr_responder_exec.sv
// alu_exec_unit: purely combinational result datapath on the latched operands and opcode.
module alu_exec_unit
  import alu_csr_responder_pkg::*;
(
  input  logic [ALU_DATA_BITS-1:0] i_op1,
  input  logic [ALU_DATA_BITS-1:0] i_op2,
  input  logic [ALU_OP_BITS-1:0]   i_aluop,
  output logic [ALU_DATA_BITS-1:0] o_result
);

  logic [4:0]               w_shamt;
  logic [ALU_DATA_BITS-1:0] w_prod;

  assign w_shamt = i_op2[4:0];
  assign w_prod  = i_op1 * i_op2;

  always_comb begin
    o_result = '0;
    case (i_aluop)
      ALUOP_ADD:  o_result = i_op1 + i_op2;
      ALUOP_SUB:  o_result = i_op1 - i_op2;
      ALUOP_AND:  o_result = i_op1 & i_op2;
      ALUOP_OR:   o_result = i_op1 | i_op2;
      ALUOP_XOR:  o_result = i_op1 ^ i_op2;
      ALUOP_SLL:  o_result = i_op1 << w_shamt;
      ALUOP_SRL:  o_result = i_op1 >> w_shamt;
      ALUOP_SRA:  o_result = $unsigned($signed(i_op1) >>> w_shamt);
      ALUOP_SLT:  o_result = {31'b0, $signed(i_op1) < $signed(i_op2)};
      ALUOP_SLTU: o_result = {31'b0, i_op1 < i_op2};
      ALUOP_MUL:  o_result = w_prod;
      default:    o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_csr_responder.sv
// CSR-handshaked ALU responder: collects two operands, runs a fixed-latency op, posts OP3 under protect control.
module alu_csr_responder
  import alu_csr_responder_pkg::*;
#(
  parameter int MUL_LAT  = 4,
  parameter int BASE_LAT = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ALU_DATA_BITS-1:0]    OP1,
  input  logic [ALU_DATA_BITS-1:0]    OP2,
  input  logic [ALU_OP_BITS-1:0]      ALUOP,
  input  logic [ALU_CSR_IN_BITS-1:0]  CSR_ALU_IN,
  output logic [ALU_DATA_BITS-1:0]    OP3,
  output logic [ALU_CSR_OUT_BITS-1:0] CSR_ALU_OUT,
  output logic                        proto_err,
  output state_e                      o_dbg_state
);

  // Handshake: a ready bit in CSR_ALU_OUT advertises the one strobe accepted this cycle;
  // a strobe counts only on a clock edge where its ready bit is high, otherwise it is a protocol error.
  state_e                      r_state;
  state_e                      w_next;
  logic [ALU_DATA_BITS-1:0]    r_op1;
  logic [ALU_DATA_BITS-1:0]    r_op2;
  logic [ALU_OP_BITS-1:0]      r_aluop;
  logic [CNT_BITS-1:0]         r_cnt;
  logic [ALU_DATA_BITS-1:0]    r_op3;
  logic [ALU_CSR_OUT_BITS-1:0] r_csr_out;
  logic                        r_proto_err;
  logic [ALU_DATA_BITS-1:0]    w_result;
  logic [CNT_BITS-1:0]         w_lat;
  logic                        w_proto;

  alu_exec_unit u_exec (
    .i_op1    (r_op1),
    .i_op2    (r_op2),
    .i_aluop  (r_aluop),
    .o_result (w_result)
  );

  // Counter holds remaining EXEC cycles minus one, so EXEC spans exactly the configured latency.
  assign w_lat   = (ALUOP == ALUOP_MUL) ? CNT_BITS'(MUL_LAT - 1) : CNT_BITS'(BASE_LAT - 1);
  assign w_proto = (CSR_ALU_IN[1] && (r_state != ST_READY_OP1)) ||
                   (CSR_ALU_IN[2] && (r_state != ST_READY_OP2));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_READY_OP1: if (CSR_ALU_IN[1])    w_next = ST_READY_OP2;
      ST_READY_OP2: if (CSR_ALU_IN[2])    w_next = ST_EXEC;
      ST_EXEC:      if (r_cnt == '0)      w_next = ST_WRITE;
      ST_WRITE:     if (!CSR_ALU_IN[0])   w_next = ST_DONE;
      ST_DONE:      if (CSR_ALU_IN[0])    w_next = ST_READY_OP1;
      default:                            w_next = ST_READY_OP1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_READY_OP1;
      r_op1       <= '0;
      r_op2       <= '0;
      r_aluop     <= '0;
      r_cnt       <= '0;
      r_op3       <= '0;
      r_csr_out   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_csr_out <= csr_out_for(w_next);
      if (w_proto) r_proto_err <= 1'b1;
      if ((r_state == ST_READY_OP1) && CSR_ALU_IN[1]) r_op1 <= OP1;
      if ((r_state == ST_READY_OP2) && CSR_ALU_IN[2]) begin
        r_op2   <= OP2;
        r_aluop <= ALUOP;
        r_cnt   <= w_lat;
      end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if ((r_state == ST_WRITE) && !CSR_ALU_IN[0]) r_op3 <= w_result;
    end
  end

  assign OP3         = r_op3;
  assign CSR_ALU_OUT = r_csr_out;
  assign proto_err   = r_proto_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_csr_responder.sv
// Self-checking bench for alu_csr_responder: directed cases plus randomized ops against a behavioural model.
module tb_alu_csr_responder;
  import alu_csr_responder_pkg::*;

  localparam int MUL_LAT  = 4;
  localparam int BASE_LAT = 1;

  // Clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] op1, op2;
  logic [3:0]  aluop;
  logic [2:0]  csr_in;
  logic [31:0] op3;
  logic [2:0]  csr_out;
  logic        proto_err;
  state_e      dbg_state;

  always #5 clk = ~clk;

  alu_csr_responder #(.MUL_LAT(MUL_LAT), .BASE_LAT(BASE_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .OP1         (op1),
    .OP2         (op2),
    .ALUOP       (aluop),
    .CSR_ALU_IN  (csr_in),
    .OP3         (op3),
    .CSR_ALU_OUT (csr_out),
    .proto_err   (proto_err),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic straight from the opcode table
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int          sa, sb;
    logic [63:0] p;
    sa = a;
    sb = b;
    p  = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return 32'($signed(a) >>> b[4:0]);
      4'd8:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return p[31:0];
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural model: transaction phases, updated on each rising edge
  localparam int P_WANT_A = 0, P_WANT_B = 1, P_BUSY = 2, P_PENDING = 3, P_POSTED = 4;
  int          m_phase;
  int          m_left;
  logic [31:0] m_a, m_b, m_op3;
  logic [3:0]  m_op;
  logic        m_err;
  logic [2:0]  m_out;
  bit          m_valid = 0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_phase = P_WANT_A; m_left = 0; m_a = 0; m_b = 0; m_op = 0;
      m_op3 = 0; m_err = 0; m_out = 3'b000; m_valid = 1;
    end else if (m_valid) begin
      if ((csr_in[1] && m_phase != P_WANT_A) || (csr_in[2] && m_phase != P_WANT_B)) m_err = 1;
      case (m_phase)
        P_WANT_A: if (csr_in[1]) begin m_a = op1; m_phase = P_WANT_B; end
        P_WANT_B: if (csr_in[2]) begin
          m_b = op2; m_op = aluop;
          m_left = (aluop == 4'd10) ? MUL_LAT : BASE_LAT;
          m_phase = P_BUSY;
        end
        P_BUSY: begin
          m_left = m_left - 1;
          if (m_left == 0) m_phase = P_PENDING;
        end
        P_PENDING: if (!csr_in[0]) begin m_op3 = alu_ref(m_a, m_b, m_op); m_phase = P_POSTED; end
        default: if (csr_in[0]) m_phase = P_WANT_A;
      endcase
      m_out = (m_phase == P_WANT_A) ? 3'b001 : (m_phase == P_WANT_B) ? 3'b010 :
              (m_phase == P_POSTED) ? 3'b100 : 3'b000;
    end
  end

  // Scoreboard compare: every falling edge once the model has seen reset
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("cmp_op3", op3, m_op3);
      check("cmp_csr_out", {29'b0, csr_out}, {29'b0, m_out});
      check("cmp_proto_err", {31'b0, proto_err}, {31'b0, m_err});
      check("csr_onehot", {31'b0, ($countones(csr_out) <= 1)}, 32'd1);
    end
  end

  // Driver tasks
  task automatic wait_bit(input int b, input string name);
    bit seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (csr_out[b]) seen = 1;
      else @(negedge clk);
    end
    check(name, {31'b0, seen}, 32'd1);
  endtask

  task automatic strobe1(input logic [31:0] a);
    op1 = a; csr_in[1] = 1'b1;
    @(negedge clk);
    csr_in[1] = 1'b0; op1 = $urandom;
  endtask

  task automatic strobe2(input logic [31:0] b, input logic [3:0] op);
    op2 = b; aluop = op; csr_in[2] = 1'b1;
    @(negedge clk);
    csr_in[2] = 1'b0; op2 = $urandom; aluop = 4'($urandom);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input int hold, output logic [31:0] res);
    csr_in[0] = (hold > 0);
    wait_bit(0, "wait_rdy1");
    strobe1(a);
    wait_bit(1, "wait_rdy2");
    strobe2(b, op);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      csr_in[0] = 1'b0;
    end
    wait_bit(2, "wait_valid");
    res = op3;
    csr_in[0] = 1'b1;
    @(negedge clk);
    csr_in[0] = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] res;

  initial begin
    reset = 1'b1; op1 = 0; op2 = 0; aluop = 0; csr_in = 3'b000;

    check("ref_add", alu_ref(32'd5, 32'd7, 4'd0), 32'd12);
    check("ref_slt", alu_ref(32'hFFFF_FFFF, 32'd1, 4'd8), 32'd1);
    check("ref_sltu", alu_ref(32'hFFFF_FFFF, 32'd1, 4'd9), 32'd0);
    check("ref_mul_wrap", alu_ref(32'h1_0000, 32'h1_0000, 4'd10), 32'd0);
    check("ref_sra", alu_ref(32'h8000_0000, 32'd4, 4'd7), 32'hF800_0000);
    check("ref_illegal", alu_ref(32'd3, 32'd9, 4'd13), 32'd0);

    // Reset values, then ready for OP1 on the first cycle out of reset
    repeat (2) @(negedge clk);
    check("rst_csr_out", {29'b0, csr_out}, 32'd0);
    check("rst_op3", op3, 32'd0);
    check("rst_proto_err", {31'b0, proto_err}, 32'd0);
    check("rst_state", {29'b0, dbg_state}, {29'b0, ST_READY_OP1});
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_rdy1", {29'b0, csr_out}, 32'b001);

    // 5 + 7 with one EXEC cycle
    run_op(32'd5, 32'd7, 4'd0, 0, res);
    check("add_5_7", res, 32'd12);

    // Result held back by protect for 20 cycles
    csr_in[0] = 1'b1;
    wait_bit(0, "hold_rdy1");
    strobe1(32'd3);
    wait_bit(1, "hold_rdy2");
    strobe2(32'd4, 4'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_valid_low", {31'b0, csr_out[2]}, 32'd0);
      check("hold_op3_kept", op3, 32'd12);
    end
    csr_in[0] = 1'b0;
    @(negedge clk);
    check("hold_release_csr", {29'b0, csr_out}, 32'b100);
    check("hold_release_op3", op3, 32'd7);
    csr_in[0] = 1'b1;
    @(negedge clk);
    csr_in[0] = 1'b0;

    // MUL wrap with exact valid timing
    wait_bit(0, "mul_rdy1");
    strobe1(32'h1_0000);
    wait_bit(1, "mul_rdy2");
    op2 = 32'h1_0000; aluop = 4'd10; csr_in[2] = 1'b1;
    for (int i = 0; i <= MUL_LAT + 1; i++) begin
      @(negedge clk);
      if (i == 0) begin csr_in[2] = 1'b0; op2 = $urandom; aluop = 4'($urandom); end
      check("mul_valid_timing", {31'b0, csr_out[2]}, {31'b0, (i == MUL_LAT + 1)});
    end
    check("mul_wrap_op3", op3, 32'd0);
    csr_in[0] = 1'b1;
    @(negedge clk);
    csr_in[0] = 1'b0;

    // Signed vs unsigned compare
    run_op(32'hFFFF_FFFF, 32'd1, 4'd8, 0, res);
    check("slt_neg1_1", res, 32'd1);
    run_op(32'hFFFF_FFFF, 32'd1, 4'd9, 2, res);
    check("sltu_max_1", res, 32'd0);

    // OP2 strobe while waiting for OP1: ignored, sticky error
    wait_bit(0, "perr_rdy1");
    csr_in[2] = 1'b1; op2 = 32'hDEAD;
    @(negedge clk);
    csr_in[2] = 1'b0;
    check("perr_state_kept", {29'b0, csr_out}, 32'b001);
    check("perr_flag", {31'b0, proto_err}, 32'd1);
    check("perr_dbg_state", {29'b0, dbg_state}, {29'b0, ST_READY_OP1});

    // Both strobes together: only OP1 taken
    op1 = 32'd40; csr_in[2:1] = 2'b11;
    @(negedge clk);
    csr_in[2:1] = 2'b00;
    check("both_strobe_csr", {29'b0, csr_out}, 32'b010);
    strobe2(32'd2, 4'd0);
    wait_bit(2, "both_valid");
    check("both_strobe_op3", op3, 32'd42);
    csr_in[0] = 1'b1;
    @(negedge clk);
    csr_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("perr_sticky", {31'b0, proto_err}, 32'd1);

    // Reset mid-EXEC of a MUL
    wait_bit(0, "abort_rdy1");
    strobe1(32'd6);
    wait_bit(1, "abort_rdy2");
    strobe2(32'd7, 4'd10);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_csr_out", {29'b0, csr_out}, 32'd0);
    check("abort_op3", op3, 32'd0);
    check("abort_perr_clr", {31'b0, proto_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_rdy1_back", {29'b0, csr_out}, 32'b001);

    // Randomized operations, checked by the scoreboard every cycle
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      run_op(ra, rb, 4'($urandom_range(0, 15)), $urandom_range(0, 3), res);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_csr_responder.md
ALU_CSR_RESPONDER -- requirements
Module: alu_csr_responder

Interface
REQ-001 The module SHALL have parameter MUL_LAT, default 4, meaning EXEC cycles for MUL (legal range 1..15).
REQ-002 The module SHALL have parameter BASE_LAT, default 1, meaning EXEC cycles for all non-MUL ops (legal range 1..15).
REQ-003 The module SHALL have port clk  in  1  sole clock, all state updates on its rising edge.
REQ-004 The module SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 The module SHALL have port OP1  in  `ALUDATABITS (32)  operand 1, valid while CSR_ALU_IN[1]=1.
REQ-006 The module SHALL have port OP2  in  `ALUDATABITS (32)  operand 2, valid while CSR_ALU_IN[2]=1.
REQ-007 The module SHALL have port ALUOP  in  `ALUOPBITS (4)  operation code, sampled together with OP2.
REQ-008 The module SHALL have port CSR_ALU_IN  in  `ALUCSRINBITS (3)  with [0]=result protect, [1]=OP1 stable, [2]=OP2 stable.
REQ-009 The module SHALL have port OP3  out  `ALUDATABITS (32)  registered result.
REQ-010 The module SHALL have port CSR_ALU_OUT  out  `ALUCSROUTBITS (3)  registered, with [0]=OP1 ready, [1]=OP2 ready, [2]=result valid.
REQ-011 The module SHALL have port proto_err  out  1  sticky flag for stable strobes seen in the wrong state.

Function
REQ-012 The FSM SHALL have states READY_OP1, READY_OP2, EXEC, WRITE, DONE.
REQ-013 In READY_OP1, CSR_ALU_OUT[0] SHALL be 1; on CSR_ALU_IN[1]=1, the module SHALL latch OP1 and go to READY_OP2, and CSR_ALU_OUT[0] SHALL drop the following cycle.
REQ-014 In READY_OP2, CSR_ALU_OUT[1] SHALL be 1; on CSR_ALU_IN[2]=1, the module SHALL latch OP2 and ALUOP, load the latency counter, and go to EXEC.
REQ-015 In EXEC, the latency counter SHALL decrement once per cycle; at zero the FSM SHALL go to WRITE, so EXEC lasts MUL_LAT cycles for MUL and BASE_LAT cycles otherwise.
REQ-016 In WRITE, OP3 SHALL NOT change while CSR_ALU_IN[0]=1; on the first cycle with CSR_ALU_IN[0]=0, OP3 SHALL load the result, CSR_ALU_OUT[2] SHALL be set, and the FSM SHALL go to DONE.
REQ-017 In DONE, OP3 and CSR_ALU_OUT[2] SHALL hold; on CSR_ALU_IN[0]=1 (protect acknowledged), the FSM SHALL go to READY_OP1 and clear CSR_ALU_OUT[2].
REQ-018 OP3 SHALL change only in WRITE; it SHALL hold across READY_OP1/READY_OP2/EXEC until the next WRITE.
REQ-019 At most one CSR_ALU_OUT bit SHALL be 1 in any cycle.
REQ-020 ALUOP encoding SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 0/1), 9 SLTU, 10 MUL (low 32 bits of product); codes 11-15 SHALL produce 0 with BASE_LAT.
REQ-021 ADD/SUB/MUL SHALL wrap modulo 2^32; shift amount SHALL be OP2[4:0].
REQ-022 CSR_ALU_IN[1]=1 outside READY_OP1, or CSR_ALU_IN[2]=1 outside READY_OP2, SHALL be ignored functionally and SHALL set proto_err.
REQ-023 If CSR_ALU_IN[1] and CSR_ALU_IN[2] are both 1 in READY_OP1, only OP1 SHALL be taken and proto_err SHALL be set.
REQ-024 Changes on OP1/OP2/ALUOP outside their strobe cycles SHALL have no effect on an operation in flight.

Reset
REQ-025 While reset=1, state SHALL be READY_OP1, CSR_ALU_OUT SHALL be 3'b000, OP3 SHALL be 0, proto_err SHALL be 0, and operand latches and the latency counter SHALL be 0.
REQ-026 CSR_ALU_OUT[0] SHALL rise on the first cycle after reset deasserts.
REQ-027 Reset asserted in any state, including mid-EXEC, SHALL abort the operation with no OP3 update.

Structure
REQ-028 ALUOP encodings and the width macros (ALUDATABITS, ALUOPBITS, ALUCSRINBITS, ALUCSROUTBITS) SHALL live in the shared define.vh.
REQ-029 The result datapath SHALL be one sub-module, alu_exec_unit, which is combinational on the latched operands and ALUOP; the parent owns the FSM, counter and OP3 register.

Verification
REQ-030 Reset, then OP1=5 strobe, OP2=7 strobe, ALUOP=0, protect low -> CSR_ALU_OUT[2]=1, OP3=12, with 1 EXEC cycle.
REQ-031 ALUOP=10, OP1=0x10000, OP2=0x10000 -> OP3=0 (wrap) and CSR_ALU_OUT[2] rises exactly MUL_LAT+1 cycles after the OP2 strobe when protect is already low.
REQ-032 Result ready while protect held at 1 for 20 cycles -> OP3 unchanged, CSR_ALU_OUT[2]=0 until protect drops, then OP3 updates.
REQ-033 ALUOP=8, OP1=0xFFFFFFFF, OP2=1 -> OP3=1; ALUOP=9 with the same operands -> OP3=0.
REQ-034 CSR_ALU_IN[2] pulsed in READY_OP1 -> state unchanged, proto_err=1 and staying 1 until reset.
REQ-035 Reset mid-EXEC of MUL -> next cycle CSR_ALU_OUT=000, OP3=0, then CSR_ALU_OUT=001.
